// File: rtl/mem_access_unit.sv
// Memory-stage access unit: kernel-memory reads, pixel-ROM reads and picture-RAM writes
// sequenced by a small FSM that stalls the pipeline while a command is in flight.
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int KDEPTH      = 9,
    parameter int ROM_LAT     = 2,
    parameter int RAM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [6:0]        ctrl,
    input  logic [17:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [3:0]        k_addr,
    input  logic [DATA_W-1:0] k_rdata,
    output logic              rom_en,
    output logic [17:0]       rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              ram_we,
    output logic [17:0]       ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    output logic              err
);

    localparam logic [6:0] CMD_KADDR = 7'b1100010;
    localparam logic [6:0] CMD_KIDX  = 7'b1101010;
    localparam logic [6:0] CMD_ROM   = 7'b1001110;
    localparam logic [6:0] CMD_RAM   = 7'b0100001;
    localparam int CNT_W = (RAM_TIMEOUT > 7) ? $clog2(RAM_TIMEOUT + 1) : 3;

    typedef enum logic [2:0] {IDLE, KREAD, ROMWAIT, RAMWR, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          kidx_q, kidx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [3:0]          k_addr_q, k_addr_d;
    logic [17:0]         rom_addr_q, rom_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [17:0]         ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                err_q, err_d;

    logic acc_ok_s, acc_kaddr_s, acc_kidx_s, acc_rom_s, acc_ram_s, acc_s;

    // Acceptance is gated by reset so the combinational outputs also show reset values.
    assign acc_ok_s    = (state_q == IDLE) && req_valid && !reset;
    assign acc_kaddr_s = acc_ok_s && (ctrl == CMD_KADDR);
    assign acc_kidx_s  = acc_ok_s && (ctrl == CMD_KIDX);
    assign acc_rom_s   = acc_ok_s && (ctrl == CMD_ROM);
    assign acc_ram_s   = acc_ok_s && (ctrl == CMD_RAM);
    assign acc_s       = acc_kaddr_s || acc_kidx_s || acc_rom_s || acc_ram_s;

    // Next-state and datapath update for the command sequencer.
    always_comb begin
        state_d     = state_q;
        kidx_d      = kidx_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        k_addr_d    = k_addr_q;
        rom_addr_d  = rom_addr_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (acc_kaddr_s) begin
                    k_addr_d = addr[3:0];
                    state_d  = KREAD;
                end else if (acc_kidx_s) begin
                    k_addr_d = kidx_q;
                    kidx_d   = (kidx_q == 4'(KDEPTH - 1)) ? 4'd0 : kidx_q + 4'd1;
                    state_d  = KREAD;
                end else if (acc_rom_s) begin
                    rom_addr_d = addr;
                    cnt_d      = CNT_W'(ROM_LAT);
                    state_d    = ROMWAIT;
                end else if (acc_ram_s) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = addr;
                    ram_wdata_d = wdata;
                    cnt_d       = '0;
                    state_d     = RAMWR;
                end else begin
                    state_d = IDLE;
                end
            end
            KREAD: begin
                rdata_d  = k_rdata;
                rvalid_d = 1'b1;
                state_d  = DONE;
            end
            ROMWAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    rdata_d  = rom_rdata;
                    rvalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RAMWR: begin
                // An acknowledge in the final allowed cycle still counts as success.
                if (ram_ack) begin
                    ram_we_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_W'(RAM_TIMEOUT - 1)) begin
                    ram_we_d = 1'b0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            kidx_q      <= 4'd0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            k_addr_q    <= 4'd0;
            rom_addr_q  <= 18'd0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 18'd0;
            ram_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kidx_q      <= kidx_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            k_addr_q    <= k_addr_d;
            rom_addr_q  <= rom_addr_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            err_q       <= err_d;
        end
    end

    // Memory addresses must be presented in the accept cycle itself.
    assign k_addr    = (acc_kaddr_s || acc_kidx_s) ? k_addr_d : k_addr_q;
    assign rom_en    = acc_rom_s;
    assign rom_addr  = acc_rom_s ? addr : rom_addr_q;
    assign stall     = acc_s || ((state_q != IDLE) && (state_q != DONE));
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and random commands against a
// command-level reference model of latencies, kernel index, read data and error flag.
module tb_mem_access_unit;

    localparam int DATA_W      = 32;
    localparam int KDEPTH      = 9;
    localparam int ROM_LAT     = 2;
    localparam int RAM_TIMEOUT = 15;

    localparam logic [6:0] C_KADDR = 7'b1100010;
    localparam logic [6:0] C_KIDX  = 7'b1101010;
    localparam logic [6:0] C_ROM   = 7'b1001110;
    localparam logic [6:0] C_RAM   = 7'b0100001;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [6:0]        ctrl;
    logic [17:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [3:0]        k_addr;
    logic [DATA_W-1:0] k_rdata;
    logic              rom_en;
    logic [17:0]       rom_addr;
    logic [DATA_W-1:0] rom_rdata;
    logic              ram_we;
    logic [17:0]       ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_ack;
    logic              err;

    int checks   = 0;
    int failures = 0;

    int          kidx_m;
    logic [31:0] rdata_m;
    logic        err_m;
    logic [31:0] kmem [16];
    logic [31:0] rom_p1;

    mem_access_unit #(
        .DATA_W(DATA_W), .KDEPTH(KDEPTH), .ROM_LAT(ROM_LAT), .RAM_TIMEOUT(RAM_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .ctrl(ctrl), .addr(addr),
        .wdata(wdata), .stall(stall), .rdata(rdata), .rvalid(rvalid), .k_addr(k_addr),
        .k_rdata(k_rdata), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ack(ram_ack),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [17:0] a);
        return {a[13:0], a} ^ 32'h5A3C_0F96;
    endfunction

    // Kernel memory with 1-cycle read, pixel ROM with a 2-cycle read pipeline.
    always @(posedge clk) begin
        k_rdata   <= kmem[k_addr];
        rom_p1    <= rom_f(rom_addr);
        rom_rdata <= rom_p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_rec(input logic [6:0] c);
        return (c == C_KADDR) || (c == C_KIDX) || (c == C_ROM) || (c == C_RAM);
    endfunction

    // Issue one recognised command; ack_at = RAMWR cycle number carrying ram_ack (0 = never).
    task automatic run_cmd(input logic [6:0] c, input logic [17:0] a, input logic [31:0] d,
                           input int ack_at);
        int stall_cnt, rom_cnt, we_cnt, exp_stall, exp_we, ka;
        bit is_read;
        is_read = (c != C_RAM);
        exp_we  = 0;
        @(negedge clk);
        req_valid = 1'b1; ctrl = c; addr = a; wdata = d; ram_ack = 1'($urandom);
        #1;
        chk("accept_stall", 32'(stall), 32'd1);
        if (c == C_KADDR || c == C_KIDX) begin
            ka = (c == C_KADDR) ? int'(a[3:0]) : kidx_m;
            chk("k_addr", 32'(k_addr), 32'(ka));
            rdata_m = kmem[ka];
            if (c == C_KIDX) kidx_m = (kidx_m + 1) % KDEPTH;
            exp_stall = 2;
        end else if (c == C_ROM) begin
            chk("rom_addr", 32'(rom_addr), 32'(a));
            rdata_m   = rom_f(a);
            exp_stall = 1 + ROM_LAT;
        end else if (ack_at >= 1 && ack_at <= RAM_TIMEOUT) begin
            exp_stall = 1 + ack_at;
            exp_we    = ack_at;
        end else begin
            exp_stall = 1 + RAM_TIMEOUT;
            exp_we    = RAM_TIMEOUT;
            err_m     = 1'b1;
        end
        stall_cnt = 1; rom_cnt = int'(rom_en); we_cnt = 0;
        @(negedge clk);
        req_valid = 1'b0; ctrl = 7'($urandom); addr = 18'($urandom); wdata = $urandom;
        ram_ack = 1'($urandom);
        #1;
        while (stall && stall_cnt < 40) begin
            stall_cnt++;
            rom_cnt += int'(rom_en);
            if (ram_we) begin
                we_cnt++;
                chk("ram_addr_stable", 32'(ram_addr), 32'(a));
                chk("ram_wdata_stable", ram_wdata, d);
                ram_ack = (we_cnt == ack_at);
            end
            @(negedge clk);
            ctrl = 7'($urandom); addr = 18'($urandom); wdata = $urandom; ram_ack = 1'($urandom);
            #1;
        end
        chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        chk("rom_en_cycles", 32'(rom_cnt), (c == C_ROM) ? 32'd1 : 32'd0);
        chk("ram_we_cycles", 32'(we_cnt), 32'(exp_we));
        chk("done_rvalid", 32'(rvalid), is_read ? 32'd1 : 32'd0);
        chk("done_rdata", rdata, rdata_m);
        chk("done_err", 32'(err), 32'(err_m));
        chk("done_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        ram_ack = 1'b0;
        #1;
        chk("idle_rvalid", 32'(rvalid), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
    endtask

    task automatic run_noop(input logic [6:0] c, input logic rv);
        @(negedge clk);
        req_valid = rv; ctrl = c; addr = 18'($urandom); wdata = $urandom;
        #1;
        chk("noop_stall", 32'(stall), 32'd0);
        chk("noop_rom_en", 32'(rom_en), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("noop_after_stall", 32'(stall), 32'd0);
        chk("noop_ram_we", 32'(ram_we), 32'd0);
        chk("noop_rvalid", 32'(rvalid), 32'd0);
        chk("noop_rdata", rdata, rdata_m);
    endtask

    task automatic check_reset_outputs(input string where);
        chk({where, "_stall"}, 32'(stall), 32'd0);
        chk({where, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({where, "_rdata"}, rdata, 32'd0);
        chk({where, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({where, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({where, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({where, "_k_addr"}, 32'(k_addr), 32'd0);
        chk({where, "_rom_en"}, 32'(rom_en), 32'd0);
        chk({where, "_err"}, 32'(err), 32'd0);
    endtask

    // Start a command, assert reset between clock edges after 'cycles' wait cycles.
    task automatic reset_mid(input logic [6:0] c, input int cycles, input string where);
        int bad;
        @(negedge clk);
        req_valid = 1'b1; ctrl = c; addr = 18'($urandom); wdata = $urandom;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(where);
        rdata_m = 32'd0; err_m = 1'b0; kidx_m = 0;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (ram_we || rvalid || stall) bad++;
        end
        chk({where, "_quiet_after"}, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [6:0] rc;
        int kind;
        reset = 1'b1; req_valid = 1'b0; ctrl = 7'd0; addr = 18'd0; wdata = 32'd0;
        ram_ack = 1'b0;
        for (int i = 0; i < 16; i++) kmem[i] = $urandom;
        kmem[5] = 32'h0000_0007;
        kidx_m = 0; rdata_m = 32'd0; err_m = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        run_cmd(C_KADDR, 18'd5, 32'd0, 0);
        for (int i = 0; i < 10; i++) run_cmd(C_KIDX, 18'($urandom), 32'($urandom), 0);
        run_cmd(C_ROM, 18'h100, 32'd0, 0);
        run_cmd(C_RAM, 18'h20, 32'h0000_00AB, 4);
        run_noop(7'b0000000, 1'b1);
        run_noop(7'b1111111, 1'b1);
        run_noop(C_RAM, 1'b0);
        run_noop(C_KADDR, 1'b0);
        run_cmd(C_RAM, 18'($urandom), $urandom, 1);
        run_cmd(C_RAM, 18'($urandom), $urandom, RAM_TIMEOUT);
        run_cmd(C_RAM, 18'($urandom), $urandom, 0);
        run_cmd(C_KADDR, 18'($urandom), $urandom, 0);
        run_cmd(C_RAM, 18'($urandom), $urandom, 2);

        reset_mid(C_ROM, 0, "rst_romwait");
        reset_mid(C_RAM, 3, "rst_ramwr");
        run_cmd(C_KIDX, 18'($urandom), $urandom, 0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: run_cmd(C_KADDR, 18'($urandom), $urandom, 0);
                1: run_cmd(C_KIDX, 18'($urandom), $urandom, 0);
                2: run_cmd(C_ROM, 18'($urandom), $urandom, 0);
                3: run_cmd(C_RAM, 18'($urandom), $urandom, $urandom_range(0, 18));
                default: begin
                    rc = 7'($urandom);
                    if (is_rec(rc)) rc = rc ^ 7'b0010000;
                    run_noop(rc, 1'b1);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
